// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and types for the streaming dot-product engine.
//   DATA_W_DEF / ACC_W_DEF : default operand and accumulator widths
//   mac_state_t            : sequencing FSM states
//   operand_t / acc_t      : signed operand and accumulator types at default widths
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    typedef logic signed [DATA_W_DEF-1:0] operand_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

endpackage

// File: rtl/mac_dot_product_if.sv
// mac_dot_product_if: operand input stream and result output stream of the
// dot-product engine.
//   in_valid/in_ready   : operand pair handshake
//   in_a, in_b          : signed operands
//   in_bias             : signed bias, meaningful only with the first term
//   out_valid/out_ready : result handshake
//   out_result          : signed dot-product result
//   out_overflow        : sticky signed-overflow flag for the result
// slave is the engine side, master is the source/sink side.
interface mac_dot_product_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic signed [ACC_W-1:0]  in_bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_result;
    logic                     out_overflow;

    modport slave (
        input  in_valid, in_a, in_b, in_bias, out_ready,
        output in_ready, out_valid, out_result, out_overflow
    );

    modport master (
        output in_valid, in_a, in_b, in_bias, out_ready,
        input  in_ready, out_valid, out_result, out_overflow
    );
endinterface

// File: rtl/mac_acc_pipe.sv
// mac_acc_pipe: two-stage signed multiply-accumulate datapath.
//   clk, reset_n : clock, asynchronous active-low reset
//   vld          : operand pair accepted this cycle
//   first        : accepted pair is term 0 (accumulator seeded from bias)
//   clear        : result consumed, zero accumulator and overflow
//   a, b, bias   : signed operands and bias
//   busy         : a product is in flight between the two stages
//   acc          : running signed accumulator
//   overflow     : sticky signed-overflow flag
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vld,
    input  logic                     first,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     busy,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     overflow
);

    // Two same-signed addends producing a sum of the other sign.
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                     input logic signed [ACC_W-1:0] y,
                                     input logic signed [ACC_W-1:0] s);
        return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    endfunction

    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]    prod_p1;
    logic signed [ACC_W-1:0]    bias_p1;
    logic                       vld_p1;
    logic                       first_p1;
    logic signed [ACC_W-1:0]    addend_p1;
    logic signed [ACC_W-1:0]    sum_p1;

    assign prod_p0 = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    // ---- stage 1: full-width product register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
        end else begin
            vld_p1   <= vld;
            first_p1 <= vld & first;
        end
    end

    always_ff @(posedge clk) begin
        if (vld) begin
            prod_p1 <= ACC_W'(prod_p0);
            bias_p1 <= bias;
        end
    end

    // ---- stage 2: accumulate and track overflow ----
    always_comb begin
        addend_p1 = first_p1 ? bias_p1 : acc;
        sum_p1    = addend_p1 + prod_p1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (vld_p1) begin
            acc      <= sum_p1;
            overflow <= (overflow & ~first_p1) | add_ovf(addend_p1, prod_p1, sum_p1);
        end
    end

    assign busy = vld_p1;

endmodule

// File: rtl/mac_dot_product.sv
// mac_dot_product: streaming dot-product engine. Collects N_TERMS operand
// pairs, seeds the accumulator with the bias on term 0, and presents
// sum(a*b)+bias with a sticky overflow flag until it is consumed.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : operand input stream and result output stream (slave side)
module mac_dot_product
    import mac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = 8
) (
    input logic               clk,
    input logic               reset_n,
    mac_dot_product_if.slave  bus
);

    localparam int                CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_TERMS - 1);

    mac_state_t              state;
    mac_state_t              next_state;
    logic [CNT_W-1:0]        count;
    logic                    ready;
    logic                    xfer_in;
    logic                    xfer_out;
    logic                    busy;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;

    assign xfer_in  = bus.in_valid & ready;
    assign xfer_out = (state == HOLD) & bus.out_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (xfer_in) next_state = (N_TERMS == 1) ? DRAIN : ACCUM;
            ACCUM: if (xfer_in && count == LAST) next_state = DRAIN;
            // Leave once the final product has passed through stage 2.
            DRAIN: if (!busy) next_state = HOLD;
            HOLD:  if (xfer_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            ready <= 1'b0;
        end else begin
            state <= next_state;
            if (xfer_in) count <= (next_state == DRAIN) ? '0 : count + 1'b1;
            // Registered so it stays low through reset and rises one edge later.
            ready <= (next_state == IDLE) || (next_state == ACCUM);
        end
    end

    mac_acc_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .vld      (xfer_in),
        .first    (state == IDLE),
        .clear    (xfer_out),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .bias     (bus.in_bias),
        .busy     (busy),
        .acc      (acc),
        .overflow (ovf)
    );

    assign bus.in_ready     = ready;
    assign bus.out_valid    = (state == HOLD);
    assign bus.out_result   = acc;
    assign bus.out_overflow = ovf;

endmodule

// File: tb/tb_mac_dot_product.sv
// tb_mac_dot_product: table-driven and randomized bench for mac_dot_product.
// Three instances (N_TERMS = 1, 4, 2) share one set of stimulus signals;
// sel routes the handshake to one instance at a time.
module tb_mac_dot_product;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [31:0] in_bias;
    int          sel;

    int checks   = 0;
    int failures = 0;

    mac_dot_product_if #(.DATA_W(16), .ACC_W(32)) bus_n1 ();
    mac_dot_product_if #(.DATA_W(16), .ACC_W(32)) bus_n4 ();
    mac_dot_product_if #(.DATA_W(16), .ACC_W(32)) bus_n2 ();

    assign bus_n1.in_valid  = in_valid & (sel == 0);
    assign bus_n1.out_ready = out_ready & (sel == 0);
    assign bus_n1.in_a      = in_a;
    assign bus_n1.in_b      = in_b;
    assign bus_n1.in_bias   = in_bias;
    assign bus_n4.in_valid  = in_valid & (sel == 1);
    assign bus_n4.out_ready = out_ready & (sel == 1);
    assign bus_n4.in_a      = in_a;
    assign bus_n4.in_b      = in_b;
    assign bus_n4.in_bias   = in_bias;
    assign bus_n2.in_valid  = in_valid & (sel == 2);
    assign bus_n2.out_ready = out_ready & (sel == 2);
    assign bus_n2.in_a      = in_a;
    assign bus_n2.in_b      = in_b;
    assign bus_n2.in_bias   = in_bias;

    mac_dot_product #(.DATA_W(16), .ACC_W(32), .N_TERMS(1)) dut_n1 (
        .clk(clk), .reset_n(reset_n), .bus(bus_n1.slave));
    mac_dot_product #(.DATA_W(16), .ACC_W(32), .N_TERMS(4)) dut_n4 (
        .clk(clk), .reset_n(reset_n), .bus(bus_n4.slave));
    mac_dot_product #(.DATA_W(16), .ACC_W(32), .N_TERMS(2)) dut_n2 (
        .clk(clk), .reset_n(reset_n), .bus(bus_n2.slave));

    logic        ir, ov, ovf;
    logic [31:0] res;
    always_comb begin
        ir = 1'b0; ov = 1'b0; ovf = 1'b0; res = '0;
        case (sel)
            0: begin ir = bus_n1.in_ready; ov = bus_n1.out_valid; ovf = bus_n1.out_overflow; res = bus_n1.out_result; end
            1: begin ir = bus_n4.in_ready; ov = bus_n4.out_valid; ovf = bus_n4.out_overflow; res = bus_n4.out_result; end
            2: begin ir = bus_n2.in_ready; ov = bus_n2.out_valid; ovf = bus_n2.out_overflow; res = bus_n2.out_result; end
            default: ;
        endcase
    end

    // Operands of the vector being sent and the reference model over them.
    int va[256];
    int vb[256];
    int vbias;

    function automatic void model(input int n, output logic [31:0] r, output bit o);
        longint t;
        int     w;
        w = vbias;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = longint'(w) + longint'(va[i]) * longint'(vb[i]);
            w = int'(t);
            o = o | (longint'(w) != t);
        end
        r = w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Sends va/vb/vbias as one vector to the selected instance, then checks
    // latency, result, overflow, hold behaviour and the return to idle.
    task automatic do_vector(input string name, input int n, input int max_gap,
                             input int hold, input logic [31:0] exp_res, input bit exp_ovf);
        int first_acc, last_acc, gaps, budget, ovc, g;
        logic [31:0] r0;
        logic        o0;
        first_acc = 0; last_acc = 0; gaps = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
                repeat (g) begin
                    in_valid = 1'b0;
                    in_a = 16'($urandom); in_b = 16'($urandom); in_bias = $urandom;
                    @(negedge clk);
                end
                gaps += g;
            end
            in_valid = 1'b1;
            in_a     = va[i][15:0];
            in_b     = vb[i][15:0];
            in_bias  = (i == 0) ? vbias : $urandom;
            budget   = 50;
            while (!ir && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (!ir) begin
                chk({name, " in_ready timeout"}, ir, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
        end
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom);
        budget = 20;
        while (!ov && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!ov) begin
            chk({name, " out_valid timeout"}, ov, 1);
            return;
        end
        ovc = cyc;
        chk({name, " latency"}, ovc - last_acc, 2);
        chk({name, " shift"}, ovc - first_acc, n - 1 + gaps + 2);
        chk({name, " result"}, res, exp_res);
        chk({name, " overflow"}, ovf, exp_ovf);
        if (hold > 0) begin
            r0 = res; o0 = ovf;
            repeat (hold) begin
                in_valid = 1'b1;
                in_a = 16'($urandom); in_b = 16'($urandom); in_bias = $urandom;
                @(negedge clk);
                chk({name, " hold valid"}, ov, 1);
                chk({name, " hold result"}, res, r0);
                chk({name, " hold ovf"}, ovf, o0);
                chk({name, " hold ready"}, ir, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({name, " valid drop"}, ov, 0);
        chk({name, " ready back"}, ir, 1);
        out_ready = 1'b0;
    endtask

    typedef struct packed {
        int              sel;
        int              n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [31:0]     bias;
        int              max_gap;
        int              hold;
        logic [31:0]     exp_res;
        logic            exp_ovf;
    } vec_t;

    function automatic vec_t mk(input int s, input int n,
                                input int pa0, input int pb0, input int pa1, input int pb1,
                                input int pa2, input int pb2, input int pa3, input int pb3,
                                input logic [31:0] bias, input int gap, input int hold,
                                input logic [31:0] er, input logic eo);
        vec_t v;
        v.sel = s; v.n = n;
        v.a[0] = 16'(pa0); v.b[0] = 16'(pb0);
        v.a[1] = 16'(pa1); v.b[1] = 16'(pb1);
        v.a[2] = 16'(pa2); v.b[2] = 16'(pb2);
        v.a[3] = 16'(pa3); v.b[3] = 16'(pb3);
        v.bias = bias; v.max_gap = gap; v.hold = hold;
        v.exp_res = er; v.exp_ovf = eo;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] er;
        bit          eo;
        logic        spurious;
        int          budget;
        logic signed [15:0] r16a, r16b;

        tbl[0] = mk(0, 1, -5, 3, 0, 0, 0, 0, 0, 0, 32'd10, 0, 0, 32'hFFFF_FFFB, 1'b0);
        tbl[1] = mk(1, 4, 2, 2, 3, -4, -1, -1, 100, 10, -32'sd5, 0, 0, 32'h0000_03DC, 1'b0);
        tbl[2] = mk(1, 4, 2, 2, 3, -4, -1, -1, 100, 10, -32'sd5, 3, 0, 32'h0000_03DC, 1'b0);
        tbl[3] = mk(1, 4, 2, 2, 3, -4, -1, -1, 100, 10, -32'sd5, 0, 6, 32'h0000_03DC, 1'b0);
        tbl[4] = mk(2, 2, -32768, -32768, -32768, -32768, 0, 0, 0, 0, 32'd0, 0, 0, 32'h8000_0000, 1'b1);
        tbl[5] = mk(2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'h0000_0001, 1'b0);
        tbl[6] = mk(0, 1, 1, -1, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 1'b1);
        tbl[7] = mk(1, 4, -32768, -32768, -32768, -32768, -32768, -32767, 0, 0, 32'd0, 2, 0, 32'hBFFF_8000, 1'b1);
        tbl[8] = mk(0, 1, -32768, -32768, 0, 0, 0, 0, 0, 0, 32'h3FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1'b0);

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_bias = '0; sel = 0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset ready %0d", s), ir, 0);
            chk($sformatf("reset valid %0d", s), ov, 0);
            chk($sformatf("reset result %0d", s), res, 0);
            chk($sformatf("reset ovf %0d", s), ovf, 0);
        end
        reset_n = 1'b1;
        sel = 0;
        #1;
        chk("ready before first edge", ir, 0);
        @(negedge clk);
        chk("ready after first edge", ir, 1);

        for (int t = 0; t < 9; t++) begin
            sel = tbl[t].sel;
            vbias = int'(tbl[t].bias);
            for (int i = 0; i < 4; i++) begin
                va[i] = int'($signed(tbl[t].a[i]));
                vb[i] = int'($signed(tbl[t].b[i]));
            end
            do_vector($sformatf("vec%0d", t), tbl[t].n, tbl[t].max_gap, tbl[t].hold,
                      tbl[t].exp_res, tbl[t].exp_ovf);
        end

        // Asynchronous reset after two of four terms.
        sel = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7; in_bias = 32'd100;
            budget = 50;
            while (!ir && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midreset ready", ir, 0);
        chk("midreset valid", ov, 0);
        chk("midreset result", res, 0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (ov) spurious = 1'b1;
        end
        chk("no spurious valid", spurious, 0);
        chk("ready after reset", ir, 1);
        vbias = 0;
        for (int i = 0; i < 4; i++) begin va[i] = 1; vb[i] = 1; end
        do_vector("post reset", 4, 0, 0, 32'd4, 1'b0);

        // Randomized vectors against the reference model.
        for (int k = 0; k < 30; k++) begin
            int n;
            sel = k % 3;
            n = (sel == 0) ? 1 : (sel == 1) ? 4 : 2;
            for (int i = 0; i < n; i++) begin
                r16a = 16'($urandom);
                r16b = 16'($urandom);
                if ($urandom_range(0, 3) == 0) r16a = 16'sh8000;
                if ($urandom_range(0, 3) == 0) r16b = 16'sh8000;
                va[i] = int'(r16a);
                vb[i] = int'(r16b);
            end
            vbias = int'($urandom);
            model(n, er, eo);
            do_vector($sformatf("rand%0d", k), n, k % 3, $urandom_range(0, 2), er, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_dot_product.md
Name: mac_dot_product

Overview:
Streaming dot-product engine that feeds the signed 16x16 MAC datapath and drains its 32-bit result.
- Accepts N_TERMS operand pairs (a, b) over a valid/ready input stream.
- Seeds the accumulator with a bias on the first term.
- Emits sum(a*b) + bias over a valid/ready output stream.
- Sits between the sample/coefficient source and downstream audio DSP logic. It is the sequencing and collection end of the MAC interface.

Parameters:
DATA_W, 16, operand width (signed two's complement)
ACC_W, 32, accumulator/result width (signed)
N_TERMS, 8, products per dot product (1..256)

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operand pair
in_a  in  DATA_W  signed operand a
in_b  in  DATA_W  signed operand b
in_bias  in  ACC_W  signed bias, sampled only with term 0
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  ACC_W  signed dot-product result
out_overflow  out  1  sticky signed-overflow flag for this result

Behaviour:
- Reset (reset_n=0, async): state=IDLE, term count=0, accumulator=0, pipeline valid=0, in_ready=0 while asserted, out_valid=0, out_result=0, out_overflow=0. in_ready rises on the first clk edge after reset release.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready on a rising edge.
  - An output transfer occurs when out_valid & out_ready on a rising edge.
- FSM states:
  - IDLE: in_ready=1. On a transfer: capture a, b, bias, set count=1, go to ACCUM. With N_TERMS=1, go directly to DRAIN.
  - ACCUM: in_ready=1. Each transfer increments count. When the transfer with count==N_TERMS-1 occurs, go to DRAIN.
  - DRAIN: in_ready=0. Wait for the product pipeline to empty (2 cycles after the last transfer), then go to HOLD.
  - HOLD: out_valid=1, in_ready=0. out_result and out_overflow are stable until an output transfer. On that transfer: out_valid=0, clear accumulator and overflow, go to IDLE.
- Pipeline:
  - Stage 1 registers the full signed product a*b (2*DATA_W bits), sign-extended to ACC_W.
  - Stage 2 adds it into the accumulator.
  - Term 0 loads acc = bias + product. Later terms do acc = acc + product.
- Latency: out_valid asserts exactly 2 cycles after the edge that accepted the last term (no input bubbles needed).
- Input bubbles: in_valid may drop at any time mid-vector. Count and accumulator are held; the result is identical to gap-free streaming.
- Arithmetic:
  - Accumulation wraps modulo 2^ACC_W (no saturation).
  - out_overflow sets when a stage-2 add has both operands of the same sign and a sum of different sign. It is sticky until the result is consumed.
- Back-to-back vectors: the next vector cannot start until the HOLD transfer. in_ready returns to 1 on the cycle after out_valid falls. No overlap between vectors.
- out_ready high before out_valid has no effect. out_valid never deasserts without a transfer.
- Reset mid-operation discards any partial vector, pipeline contents and held result. There is no partial output.
- in_a, in_b and in_bias are ignored when no transfer occurs.

Decomposition:
- Package mac_pkg holds:
  - DATA_W_DEF=16 and ACC_W_DEF=32 constants.
  - typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} mac_state_t.
  - typedefs for the signed operand and accumulator types.
- One sub-module, mac_acc_pipe: the two-stage multiply register plus accumulate/overflow logic, with first/valid strobes in and acc/overflow out.
- The top holds the FSM, term counter and handshakes.

Test Plan:
- N_TERMS=1, a=0xFFFB (-5), b=0x0003, bias=0x0000000A, out_ready=1 -> out_valid 2 cycles after accept; out_result=0xFFFFFFFB; overflow=0.
- N_TERMS=4, pairs (2,2),(3,-4),(-1,-1),(100,10), bias=-5 -> out_result=4-12+1+1000-5=988 (0x000003DC).
- Same vector with in_valid deasserted 3 random cycles between terms -> identical result 988. The cycle of out_valid shifts by exactly the bubble count.
- out_ready held 0 for 6 cycles after out_valid -> result/overflow stable, in_ready=0, extra in_valid ignored. out_ready=1 -> one transfer, in_ready=1 on the next cycle.
- N_TERMS=2, a=b=0x8000 twice, bias=0 -> each product 0x40000000; out_result=0x80000000, out_overflow=1. The next vector (1,1) with bias 0 -> result 1, overflow 0.
- Assert reset_n=0 asynchronously after 2 of 4 terms, release, stream a full 4-term vector (1,1)x4 with bias 0 -> out_result=4; no spurious out_valid during or after the reset.
